// File: rtl/cache_line_mem_if.sv
`default_nettype none
// ============================================================================
// Module   : cache_line_mem_if
// Purpose  : Moves one cache line to/from memory as single-word req/ack beats.
//            Optional ack watchdog enabled by defining MEM_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module cache_line_mem_if #(
  parameter int WORD_W         = 32,
  parameter int WORDS_PER_LINE = 4,
  parameter int ADDR_W         = 16,
  parameter int TIMEOUT_CYCLES = 64,
  localparam int IDX_W         = $clog2(WORDS_PER_LINE),
  localparam int LINE_W        = WORD_W * WORDS_PER_LINE
) (
  input  logic                    clk,
  input  logic                    rst_b,
  input  logic                    wb_req,
  input  logic [ADDR_W-IDX_W-1:0] wb_line_addr,
  input  logic [LINE_W-1:0]       wb_line_data,
  input  logic                    fill_req,
  input  logic [ADDR_W-IDX_W-1:0] fill_line_addr,
  output logic                    busy,
  output logic                    xfer_done,
  output logic [LINE_W-1:0]       fill_line_data,
  output logic                    xfer_err,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [WORD_W-1:0]       mem_wdata,
  input  logic                    mem_ack,
  input  logic [WORD_W-1:0]       mem_rdata
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_LINE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WB   = 2'd1,
    FILL = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t                    state_q, state_d;
  logic [IDX_W-1:0]          cnt_q, cnt_d;
  logic                      pend_q, pend_d;
  logic [ADDR_W-IDX_W-1:0]   wb_addr_q, wb_addr_d;
  logic [ADDR_W-IDX_W-1:0]   fill_addr_q, fill_addr_d;
  logic [WORD_W-1:0]         wb_words_q   [WORDS_PER_LINE];
  logic [WORD_W-1:0]         wb_words_d   [WORDS_PER_LINE];
  logic [WORD_W-1:0]         fill_words_q [WORDS_PER_LINE];
  logic [WORD_W-1:0]         fill_words_d [WORDS_PER_LINE];
  logic                      xfer_active;

  assign xfer_active = (state_q == WB) || (state_q == FILL);

`ifdef MEM_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            xfer_err_q, xfer_err_d;
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pend_d       = pend_q;
    wb_addr_d    = wb_addr_q;
    fill_addr_d  = fill_addr_q;
    wb_words_d   = wb_words_q;
    fill_words_d = fill_words_q;

    case (state_q)
      IDLE: begin
        if (wb_req) begin
          state_d   = WB;
          wb_addr_d = wb_line_addr;
          for (int i = 0; i < WORDS_PER_LINE; i++) begin
            wb_words_d[i] = wb_line_data[i*WORD_W +: WORD_W];
          end
          if (fill_req) begin
            fill_addr_d = fill_line_addr;
            pend_d      = 1'b1;
          end
        end else if (fill_req) begin
          state_d     = FILL;
          fill_addr_d = fill_line_addr;
        end
      end
      WB, FILL: begin
        if (mem_ack) begin
          cnt_d = cnt_q + 1'b1;
          if (state_q == FILL) begin
            fill_words_d[cnt_q] = mem_rdata;
          end
          if (cnt_q == LAST_IDX) begin
            // A queued fill chains straight on so mem_req never drops.
            if (state_q == WB && pend_q) begin
              state_d = FILL;
              pend_d  = 1'b0;
            end else begin
              state_d = DONE;
            end
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

`ifdef MEM_TIMEOUT_EN
    to_cnt_d   = '0;
    xfer_err_d = 1'b0;
    if (xfer_active && !mem_ack) begin
      if (to_cnt_q == TO_LAST) begin
        state_d    = IDLE;
        cnt_d      = '0;
        pend_d     = 1'b0;
        xfer_err_d = 1'b1;
      end else begin
        to_cnt_d = to_cnt_q + 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      pend_q      <= 1'b0;
      wb_addr_q   <= '0;
      fill_addr_q <= '0;
      for (int i = 0; i < WORDS_PER_LINE; i++) begin
        wb_words_q[i]   <= '0;
        fill_words_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pend_q       <= pend_d;
      wb_addr_q    <= wb_addr_d;
      fill_addr_q  <= fill_addr_d;
      wb_words_q   <= wb_words_d;
      fill_words_q <= fill_words_d;
    end
  end

`ifdef MEM_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      to_cnt_q   <= '0;
      xfer_err_q <= 1'b0;
    end else begin
      to_cnt_q   <= to_cnt_d;
      xfer_err_q <= xfer_err_d;
    end
  end

  assign xfer_err = xfer_err_q;
`else
  assign xfer_err = 1'b0;
`endif

  // Bus outputs are pure decodes of flops, so they stay put across wait states.
  assign busy      = (state_q != IDLE);
  assign xfer_done = (state_q == DONE);
  assign mem_req   = xfer_active;
  assign mem_we    = (state_q == WB);
  assign mem_addr  = (state_q == WB)   ? {wb_addr_q, cnt_q}   :
                     (state_q == FILL) ? {fill_addr_q, cnt_q} : '0;
  assign mem_wdata = (state_q == WB) ? wb_words_q[cnt_q] : '0;

  for (genvar g = 0; g < WORDS_PER_LINE; g++) begin : g_pack
    assign fill_line_data[g*WORD_W +: WORD_W] = fill_words_q[g];
  end

endmodule
`default_nettype wire

// File: tb/tb_cache_line_mem_if.sv
`default_nettype none
// ============================================================================
// Module   : tb_cache_line_mem_if
// Purpose  : Directed vector bench for cache_line_mem_if (optional
//            MEM_TIMEOUT_EN section runs with TIMEOUT_CYCLES = 8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_cache_line_mem_if;

  localparam int WW  = 32;
  localparam int WPL = 4;
  localparam int AW  = 16;
  localparam int LW  = WW * WPL;

  logic            clk = 1'b0;
  logic            rst_b;
  logic            wb_req, fill_req;
  logic [AW-3:0]   wb_line_addr, fill_line_addr;
  logic [LW-1:0]   wb_line_data;
  logic            busy, xfer_done, xfer_err;
  logic [LW-1:0]   fill_line_data;
  logic            mem_req, mem_we, mem_ack;
  logic [AW-1:0]   mem_addr;
  logic [WW-1:0]   mem_wdata, mem_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cache_line_mem_if #(
    .WORD_W(WW), .WORDS_PER_LINE(WPL), .ADDR_W(AW), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .rst_b(rst_b),
    .wb_req(wb_req), .wb_line_addr(wb_line_addr), .wb_line_data(wb_line_data),
    .fill_req(fill_req), .fill_line_addr(fill_line_addr),
    .busy(busy), .xfer_done(xfer_done), .fill_line_data(fill_line_data),
    .xfer_err(xfer_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  typedef struct {
    bit           is_wb;
    bit           is_fill;
    logic [13:0]  wb_la;
    logic [LW-1:0] wb_data;
    logic [13:0]  fill_la;
    int           waits;
    logic [WW-1:0] rbase;
    int           poke;       // cycle at which a stray fill_req is raised (0 = none)
    logic [AW-1:0] exp_wb_a0;
    logic [AW-1:0] exp_fill_a0;
    int           exp_done;
    logic [LW-1:0] exp_fill;
  } vec_t;

  vec_t vecs [6];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply(input vec_t v);
    int  nwb   = v.is_wb ? WPL : 0;
    int  total = nwb + (v.is_fill ? WPL : 0);
    int  k     = 0;
    int  w     = 0;
    bit  seen  = 0;
    wb_req         = v.is_wb;
    fill_req       = v.is_fill;
    wb_line_addr   = v.wb_la;
    wb_line_data   = v.wb_data;
    fill_line_addr = v.fill_la;
    step();
    wb_req   = 1'b0;
    fill_req = 1'b0;
    for (int cyc = 1; cyc <= 60 && !seen; cyc++) begin
      fill_req = (cyc == v.poke);
      chk("busy_active", busy, 1'b1);
      chk("err_quiet", xfer_err, 1'b0);
      if (k < total) begin
        chk("req_high", mem_req, 1'b1);
        chk("done_early", xfer_done, 1'b0);
        if (k < nwb) begin
          chk("we_wb", mem_we, 1'b1);
          chk("addr_wb", mem_addr, v.exp_wb_a0 + AW'(k));
          chk("wdata_wb", mem_wdata, v.wb_data[k*WW +: WW]);
        end else begin
          chk("we_fill", mem_we, 1'b0);
          chk("addr_fill", mem_addr, v.exp_fill_a0 + AW'(k - nwb));
          chk("wdata_fill", mem_wdata, '0);
        end
        if (w == v.waits) begin
          mem_ack   = 1'b1;
          mem_rdata = (k >= nwb) ? v.rbase + WW'(k - nwb) : 32'hDEAD_BEEF;
          k++;
          w = 0;
        end else begin
          mem_ack   = 1'b0;
          mem_rdata = 32'hDEAD_BEEF;
          w++;
        end
      end else begin
        mem_ack   = 1'b0;
        mem_rdata = 32'hDEAD_BEEF;
        chk("req_low_done", mem_req, 1'b0);
        chk("done_pulse", xfer_done, 1'b1);
        chk("done_cycle", cyc, v.exp_done);
        seen = 1;
      end
      step();
    end
    fill_req = 1'b0;
    mem_ack  = 1'b0;
    if (!seen) chk("done_timeout", 1'b0, 1'b1);
    chk("busy_after", busy, 1'b0);
    chk("done_single", xfer_done, 1'b0);
    chk("fill_line", fill_line_data, v.exp_fill);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("idle_no_req", mem_req, 1'b0);
    end
  endtask

  initial begin
    vecs[0] = '{1, 0, 14'h0A5, {32'h44, 32'h33, 32'h22, 32'h11}, 14'h0, 0, 32'h0, 0,
                16'h0294, 16'h0, 5, '0};
    vecs[1] = '{0, 1, 14'h0, '0, 14'h010, 2, 32'hA0, 0,
                16'h0, 16'h0040, 13, {32'hA3, 32'hA2, 32'hA1, 32'hA0}};
    vecs[2] = '{1, 1, 14'h3FF, {32'hCAFE0004, 32'hCAFE0003, 32'hCAFE0002, 32'hCAFE0001},
                14'h001, 0, 32'hB0, 0,
                16'h0FFC, 16'h0004, 9, {32'hB3, 32'hB2, 32'hB1, 32'hB0}};
    vecs[3] = '{1, 0, 14'h2000, {32'h55550004, 32'h55550003, 32'h55550002, 32'h55550001},
                14'h0, 1, 32'h0, 0,
                16'h8000, 16'h0, 9, {32'hB3, 32'hB2, 32'hB1, 32'hB0}};
    vecs[4] = '{1, 0, 14'h001, {32'h4, 32'h3, 32'h2, 32'h1}, 14'h012, 0, 32'h0, 2,
                16'h0004, 16'h0, 5, {32'hB3, 32'hB2, 32'hB1, 32'hB0}};
    vecs[5] = '{0, 1, 14'h0, '0, 14'h005, 0, 32'hC0, 0,
                16'h0, 16'h0014, 5, {32'hC3, 32'hC2, 32'hC1, 32'hC0}};

    rst_b = 1'b0; wb_req = 1'b0; fill_req = 1'b0; mem_ack = 1'b0;
    wb_line_addr = '0; fill_line_addr = '0; wb_line_data = '0; mem_rdata = '0;
    repeat (3) step();
    rst_b = 1'b1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_req", mem_req, 1'b0);
    chk("rst_we", mem_we, 1'b0);
    chk("rst_addr", mem_addr, '0);
    chk("rst_done", xfer_done, 1'b0);
    chk("rst_err", xfer_err, 1'b0);
    chk("rst_fill", fill_line_data, '0);

    for (int i = 0; i < 5; i++) apply(vecs[i]);

    // Reset after the second acked word of a write-back.
    wb_req = 1'b1; wb_line_addr = 14'h0A5;
    wb_line_data = {32'h44, 32'h33, 32'h22, 32'h11};
    step();
    wb_req  = 1'b0;
    mem_ack = 1'b1;
    step();
    step();
    chk("mid_addr", mem_addr, 16'h0296);
    rst_b = 1'b0;
    step();
    chk("mid_rst_req", mem_req, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_done", xfer_done, 1'b0);
    chk("mid_rst_fill", fill_line_data, '0);
    rst_b = 1'b1;
    step();
    chk("idle_ack_ignored", busy, 1'b0);
    mem_ack = 1'b0;
    apply(vecs[5]);

`ifdef MEM_TIMEOUT_EN
    fill_req = 1'b1; fill_line_addr = 14'h007;
    step();
    fill_req = 1'b0;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      chk("to_err", xfer_err, (cyc == 9));
      chk("to_done", xfer_done, 1'b0);
      chk("to_req", mem_req, (cyc <= 8));
      chk("to_busy", busy, (cyc <= 8));
      step();
    end
    chk("to_fill_kept", fill_line_data, {32'hC3, 32'hC2, 32'hC1, 32'hC0});
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
